// File: rtl/dcache_pkg.sv
// Shared types for the set-associative data cache: word type, default address
// layout and the controller state encoding.
package dcache_pkg;
  typedef logic [31:0] word_t;

  localparam int DEF_NSETS    = 8;
  localparam int DEF_NWAYS    = 2;
  localparam int DEF_BLKWORDS = 2;

  localparam int IDX_W = $clog2(DEF_NSETS);
  localparam int BLK_W = $clog2(DEF_BLKWORDS);
  localparam int WAY_W = $clog2(DEF_NWAYS);
  localparam int TAG_W = 32 - IDX_W - BLK_W - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [BLK_W-1:0] blkoff;
    logic [1:0]       bytoff;
  } dcache_addr_t;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, HITCNT, FLUSHED} dcache_state_t;
endpackage

// File: rtl/dcache_assoc_if.sv
// Datapath-side and memory-side signals of one data cache.
// master = the cache, slave = datapath plus memory controller.
interface dcache_assoc_if;
  import dcache_pkg::*;

  logic  halt, dmemREN, dmemWEN;
  word_t dmemaddr, dmemstore;
  logic  dhit, flushed;
  word_t dmemload;
  logic  dREN, dWEN, dwait;
  word_t daddr, dstore, dload;

  modport master (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport slave (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_assoc_lru_rank_set.sv
// True-LRU rank vector for one set: rank 0 is MRU, the way holding rank
// NWAYS-1 is the replacement candidate.
module lru_rank_set #(
  parameter  int NWAYS = 2,
  localparam int WS    = (NWAYS > 1) ? $clog2(NWAYS) : 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          upd,
  input  logic [WS-1:0] upd_way,
  output logic [WS-1:0] victim
);
  if (NWAYS == 1) begin : g_one
    logic unused_in;
    assign unused_in = CLK ^ nRST ^ upd ^ upd_way[0];
    assign victim    = '0;
  end else begin : g_rank
    logic [NWAYS-1:0][WS-1:0] rank;

    always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
        for (int w = 0; w < NWAYS; w++) rank[w] <= WS'(w);
      end else if (upd) begin
        // ways more recent than the touched one age by one; the rest keep rank
        for (int w = 0; w < NWAYS; w++) begin
          if (WS'(w) == upd_way)          rank[w] <= '0;
          else if (rank[w] < rank[upd_way]) rank[w] <= rank[w] + 1'b1;
        end
      end
    end

    always_comb begin
      victim = '0;
      for (int w = 0; w < NWAYS; w++)
        if (rank[w] == WS'(NWAYS - 1)) victim = WS'(w);
    end
  end
endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate N-way data cache with true-LRU replacement and a
// halt-time flush that ends by storing the hit counter.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int    CPUID       = 0,
  parameter int    NSETS       = 8,
  parameter int    NWAYS       = 2,
  parameter int    BLKWORDS    = 2,
  parameter word_t HITCNT_ADDR = 32'h3100
) (
  input logic            CLK,
  input logic            nRST,
  dcache_assoc_if.master dc
);
  localparam int IW = $clog2(NSETS);
  localparam int BW = $clog2(BLKWORDS);
  localparam int BS = (BW > 0) ? BW : 1;
  localparam int WW = $clog2(NWAYS);
  localparam int WS = (WW > 0) ? WW : 1;
  localparam int TW = 30 - BW - IW;
  localparam int FW = IW + WW;
  localparam logic [BS-1:0] WLAST = BS'(BLKWORDS - 1);
  localparam logic [FW-1:0] FLAST = FW'(NSETS * NWAYS - 1);

  if (NSETS < 2 || NWAYS < 1 || NWAYS > 8 || BLKWORDS < 1 || BLKWORDS > 8 || CPUID < 0)
  begin : g_bad_cfg
    $error("dcache_assoc: unsupported configuration");
  end

  dcache_state_t state_q, state_n;
  logic [BS-1:0] wcnt_q, wcnt_n;
  logic [FW-1:0] fcnt_q, fcnt_n;
  word_t         hitcnt;
  logic [WS-1:0] vic_q, vic_sel, hway;

  logic [NSETS-1:0][NWAYS-1:0] valid, dirty;
  logic [TW-1:0] tags [NSETS][NWAYS];
  word_t         data [NSETS][NWAYS][BLKWORDS];
  logic [NSETS-1:0][WS-1:0] lru_vic;

  logic [TW-1:0] rtag;
  logic [IW-1:0] ridx, f_set;
  logic [BS-1:0] rblk;
  logic [WS-1:0] f_way;
  logic req, hit, inv_found;
  logic dhit, flushed, dren, dwen;
  word_t daddr, dstore;
  logic hit_upd, hit_wr, fill_we, fill_done, wb_done, fl_done;
  logic unused_bits;

  assign rtag        = dc.dmemaddr[31 -: TW];
  assign ridx        = dc.dmemaddr[2+BW +: IW];
  assign rblk        = (BW > 0) ? dc.dmemaddr[2 +: BS] : '0;
  assign req         = dc.dmemREN | dc.dmemWEN;
  assign f_set       = fcnt_q[FW-1 -: IW];
  assign f_way       = (WW > 0) ? fcnt_q[WS-1:0] : '0;
  assign unused_bits = ^dc.dmemaddr[1:0];

  function automatic word_t mk_addr(logic [TW-1:0] t, logic [IW-1:0] i, logic [BS-1:0] b);
    return (word_t'({t, i}) << (2 + BW)) | (word_t'(b) << 2);
  endfunction

  // tag match and victim choice: lowest invalid way first, else the LRU way
  always_comb begin
    hit       = 1'b0;
    hway      = '0;
    inv_found = 1'b0;
    vic_sel   = lru_vic[ridx];
    for (int w = 0; w < NWAYS; w++) begin
      if (valid[ridx][w] && tags[ridx][w] == rtag) begin
        hit  = 1'b1;
        hway = WS'(w);
      end
      if (!valid[ridx][w] && !inv_found) begin
        inv_found = 1'b1;
        vic_sel   = WS'(w);
      end
    end
  end

  for (genvar s = 0; s < NSETS; s++) begin : g_lru
    lru_rank_set #(.NWAYS(NWAYS)) u_lru (
      .CLK     (CLK),
      .nRST    (nRST),
      .upd     (hit_upd && (ridx == IW'(s))),
      .upd_way (hway),
      .victim  (lru_vic[s])
    );
  end

  always_comb begin
    state_n   = state_q;
    wcnt_n    = wcnt_q;
    fcnt_n    = fcnt_q;
    dhit      = 1'b0;
    flushed   = 1'b0;
    dren      = 1'b0;
    dwen      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    hit_upd   = 1'b0;
    hit_wr    = 1'b0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    wb_done   = 1'b0;
    fl_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc.halt) begin
          state_n = FLUSH;
          fcnt_n  = '0;
          wcnt_n  = '0;
        end else if (req && hit) begin
          dhit    = 1'b1;
          hit_upd = 1'b1;
          hit_wr  = dc.dmemWEN;
        end else if (req) begin
          state_n = dirty[ridx][vic_sel] ? WB : FETCH;
        end
      end
      WB: begin
        dwen   = 1'b1;
        daddr  = mk_addr(tags[ridx][vic_q], ridx, wcnt_q);
        dstore = data[ridx][vic_q][wcnt_q];
        if (!dc.dwait) begin
          if (wcnt_q == WLAST) begin
            wcnt_n  = '0;
            wb_done = 1'b1;
            state_n = FETCH;
          end else wcnt_n = wcnt_q + 1'b1;
        end
      end
      FETCH: begin
        dren  = 1'b1;
        daddr = mk_addr(rtag, ridx, wcnt_q);
        if (!dc.dwait) begin
          fill_we = 1'b1;
          if (wcnt_q == WLAST) begin
            wcnt_n    = '0;
            fill_done = 1'b1;
            state_n   = IDLE;
          end else wcnt_n = wcnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (dirty[f_set][f_way]) begin
          dwen   = 1'b1;
          daddr  = mk_addr(tags[f_set][f_way], f_set, wcnt_q);
          dstore = data[f_set][f_way][wcnt_q];
        end
        // clean lines advance at once; dirty ones only after their last word
        if (!dirty[f_set][f_way] || (!dc.dwait && wcnt_q == WLAST)) begin
          wcnt_n  = '0;
          fl_done = dirty[f_set][f_way];
          if (fcnt_q == FLAST) state_n = HITCNT;
          else                 fcnt_n  = fcnt_q + 1'b1;
        end else if (!dc.dwait) wcnt_n = wcnt_q + 1'b1;
      end
      HITCNT: begin
        dwen   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt;
        if (!dc.dwait) state_n = FLUSHED;
      end
      FLUSHED: flushed = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      hitcnt  <= '0;
      vic_q   <= '0;
      valid   <= '0;
      dirty   <= '0;
    end else begin
      state_q <= state_n;
      wcnt_q  <= wcnt_n;
      fcnt_q  <= fcnt_n;
      if (state_q == IDLE && state_n != IDLE) vic_q <= vic_sel;
      if (hit_upd && hitcnt != '1) hitcnt <= hitcnt + 32'd1;
      if (hit_wr)  dirty[ridx][hway]  <= 1'b1;
      if (wb_done) dirty[ridx][vic_q] <= 1'b0;
      if (fill_done) begin
        valid[ridx][vic_q] <= 1'b1;
        dirty[ridx][vic_q] <= 1'b0;
      end
      if (fl_done) dirty[f_set][f_way] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (hit_wr)    data[ridx][hway][rblk]    <= dc.dmemstore;
    if (fill_we)   data[ridx][vic_q][wcnt_q] <= dc.dload;
    if (fill_done) tags[ridx][vic_q]         <= rtag;
  end

  assign dc.dhit     = dhit;
  assign dc.dmemload = dhit ? data[ridx][hway][rblk] : '0;
  assign dc.flushed  = flushed;
  assign dc.dREN     = dren;
  assign dc.dWEN     = dwen;
  assign dc.daddr    = daddr;
  assign dc.dstore   = dstore;
endmodule

// File: tb/tb_dcache_assoc.sv
// Randomised bench for dcache_assoc: two configurations run one after the
// other against a tag-level LRU model and a flat reference memory.
module tb_dcache_assoc;
  import dcache_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic  rst0, rst1, sel;
  logic  halt, ren, wen, dwait;
  word_t addr, store, dload;

  dcache_assoc_if if0();
  dcache_assoc_if if1();

  assign if0.halt = halt;  assign if0.dmemREN = ren;  assign if0.dmemWEN = wen;
  assign if0.dmemaddr = addr;  assign if0.dmemstore = store;
  assign if0.dwait = dwait;  assign if0.dload = dload;
  assign if1.halt = halt;  assign if1.dmemREN = ren;  assign if1.dmemWEN = wen;
  assign if1.dmemaddr = addr;  assign if1.dmemstore = store;
  assign if1.dwait = dwait;  assign if1.dload = dload;

  logic  o_dhit, o_flushed, o_dREN, o_dWEN;
  word_t o_dmemload, o_daddr, o_dstore;
  assign o_dhit     = sel ? if1.dhit     : if0.dhit;
  assign o_flushed  = sel ? if1.flushed  : if0.flushed;
  assign o_dREN     = sel ? if1.dREN     : if0.dREN;
  assign o_dWEN     = sel ? if1.dWEN     : if0.dWEN;
  assign o_dmemload = sel ? if1.dmemload : if0.dmemload;
  assign o_daddr    = sel ? if1.daddr    : if0.daddr;
  assign o_dstore   = sel ? if1.dstore   : if0.dstore;

  dcache_assoc #(.CPUID(0), .NSETS(8), .NWAYS(2), .BLKWORDS(2), .HITCNT_ADDR(32'h3100))
    u_dut0 (.CLK(CLK), .nRST(rst0), .dc(if0));
  dcache_assoc #(.CPUID(1), .NSETS(8), .NWAYS(4), .BLKWORDS(4), .HITCNT_ADDR(32'h3100))
    u_dut1 (.CLK(CLK), .nRST(rst1), .dc(if1));

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference state: backing memory, program-visible memory, per-set MRU-first block lists
  word_t mem  [word_t];
  word_t refm [word_t];
  int    lru_q [8][$];
  bit    dirtyb [int];
  int    nw, bw, hits, dw_pct, stall_n;
  bit    stall_req;
  word_t last_addr;

  function automatic word_t init_val(input word_t a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction
  function automatic word_t mem_rd(input word_t a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic word_t ref_rd(input word_t a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) lru_q[s].delete();
    dirtyb.delete();
    hits = 0;
  endtask

  task automatic pick_dwait();
    if (stall_n > 0) begin
      dwait = 1'b1;
      stall_n--;
    end else dwait = ($urandom_range(0, 99) < dw_pct);
  endtask

  task automatic access(input bit wr, input word_t a, input word_t d);
    int blk, s, pos, vic, nwb, nrd;
    bit exp_hit, exp_wb, done, first, prev_stall;
    word_t exp_rd;
    logic [65:0] prev_vec;
    blk = int'(a) / (4 * bw);
    s = blk % 8;
    pos = -1;
    vic = -1;
    exp_wb = 1'b0;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == blk) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) lru_q[s].delete(pos);
    else if (lru_q[s].size() == nw) begin
      vic = lru_q[s].pop_back();
      exp_wb = dirtyb.exists(vic);
      dirtyb.delete(vic);
    end
    lru_q[s].push_front(blk);
    exp_rd = ref_rd(a);
    if (wr) begin
      refm[a] = d;
      dirtyb[blk] = 1'b1;
    end
    hits++;
    last_addr = a;

    ren = !wr; wen = wr; addr = a; store = d;
    nwb = 0; nrd = 0; done = 1'b0; first = 1'b1; prev_stall = 1'b0; prev_vec = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge CLK);
      if (first) chk("hit_class", o_dhit, exp_hit);
      first = 1'b0;
      if (prev_stall) chk("dwait_hold", {o_dREN, o_dWEN, o_daddr, o_dstore}, prev_vec);
      if (o_dhit) begin
        if (!wr) chk("rdata", o_dmemload, exp_rd);
        chk("hit_nobus", o_dREN | o_dWEN, 0);
        chk("wb_words", nwb, exp_wb ? bw : 0);
        chk("fetch_words", nrd, exp_hit ? 0 : bw);
        done = 1'b1;
        dwait = 1'b0;
      end else begin
        if (stall_req && o_dWEN && nwb == 1) begin
          stall_n = 3;
          stall_req = 1'b0;
        end
        pick_dwait();
        if (o_dWEN && !dwait) begin
          chk("wb_addr", o_daddr, word_t'((vic * bw + nwb) * 4));
          chk("wb_data", o_dstore, ref_rd(o_daddr));
          mem[o_daddr] = o_dstore;
          nwb++;
        end
        if (o_dREN && !dwait) begin
          chk("rd_addr", o_daddr, word_t'((blk * bw + nrd) * 4));
          dload = mem_rd(o_daddr);
          nrd++;
        end
      end
      prev_stall = (o_dREN | o_dWEN) && dwait;
      prev_vec = {o_dREN, o_dWEN, o_daddr, o_dstore};
      @(posedge CLK); #1;
    end
    ren = 1'b0; wen = 1'b0;
    if (!done) chk("access_timeout", 0, 1);
  endtask

  task automatic rand_access();
    int blk;
    word_t a;
    blk = $urandom_range(0, 47);
    a = word_t'((blk * bw + int'($urandom_range(0, bw - 1))) * 4);
    access($urandom_range(0, 1) == 1, a, $urandom);
  endtask

  task automatic flush_run();
    int nfw, ndirty, blk;
    bit got_hc, fin;
    ndirty = dirtyb.size();
    nfw = 0; got_hc = 1'b0; fin = 1'b0;
    halt = 1'b1;
    ren = 1'b1; addr = last_addr;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge CLK);
      chk("flush_dhit", o_dhit, 0);
      chk("flush_dren", o_dREN, 0);
      if (o_flushed) fin = 1'b1;
      else begin
        pick_dwait();
        if (o_dWEN && !dwait) begin
          if (o_daddr == 32'h3100) begin
            chk("hitcnt_val", o_dstore, hits);
            got_hc = 1'b1;
          end else begin
            blk = int'(o_daddr) / (4 * bw);
            chk("flush_blk_dirty", dirtyb.exists(blk), 1);
            chk("flush_data", o_dstore, ref_rd(o_daddr));
            chk("flush_before_hc", got_hc, 0);
            mem[o_daddr] = o_dstore;
            nfw++;
          end
        end
      end
      @(posedge CLK); #1;
    end
    ren = 1'b0;
    chk("flush_done", fin, 1);
    chk("flush_words", nfw, ndirty * bw);
    chk("hitcnt_written", got_hc, 1);
    foreach (refm[k]) chk("mem_final", mem_rd(k), refm[k]);
    ren = 1'b1; addr = 32'h40;
    repeat (4) begin
      @(negedge CLK);
      chk("flushed_hold", o_flushed, 1);
      chk("flushed_dhit", o_dhit, 0);
      chk("flushed_nobus", o_dREN | o_dWEN, 0);
    end
    @(posedge CLK); #1;
    ren = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dhit"}, o_dhit, 0);
    chk({tag, "_flushed"}, o_flushed, 0);
    chk({tag, "_bus"}, {o_dREN, o_dWEN}, 0);
    chk({tag, "_daddr"}, o_daddr, 0);
    chk({tag, "_dstore"}, o_dstore, 0);
    chk({tag, "_dmemload"}, o_dmemload, 0);
  endtask

  initial begin
    bit got;
    n_chk = 0; n_fail = 0;
    sel = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
    halt = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
    dwait = 1'b0; dload = '0; dw_pct = 0; stall_n = 0; stall_req = 1'b0; last_addr = '0;

    // configuration 1: 2 ways, 2-word blocks
    nw = 2; bw = 2; model_reset();
    repeat (2) @(negedge CLK);
    chk_reset_outs("rst0");
    rst0 = 1'b1;
    @(posedge CLK); #1;
    mem[32'h40] = 32'hA;  refm[32'h40] = 32'hA;
    mem[32'h44] = 32'hB;  refm[32'h44] = 32'hB;
    access(1'b0, 32'h40, 0);
    access(1'b1, 32'h44, 32'h55);
    access(1'b0, 32'h140, 0);
    stall_req = 1'b1;
    access(1'b0, 32'h240, 0);
    stall_req = 1'b0;
    access(1'b0, 32'h44, 0);
    dw_pct = 30;
    repeat (150) rand_access();
    flush_run();

    // configuration 2: 4 ways, 4-word blocks
    rst0 = 1'b0; halt = 1'b0; sel = 1'b1; dw_pct = 0;
    nw = 4; bw = 4; model_reset();
    @(negedge CLK);
    chk_reset_outs("rst1");
    rst1 = 1'b1;
    @(posedge CLK); #1;

    // asynchronous reset in the middle of a fill leaves the line invalid
    ren = 1'b1; addr = 32'h80; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (o_dREN) begin
        got = 1'b1;
        dwait = 1'b0;
        dload = mem_rd(o_daddr);
      end
    end
    chk("arst_fetch_started", got, 1);
    @(posedge CLK); #2;
    rst1 = 1'b0;
    #1;
    chk_reset_outs("arst");
    ren = 1'b0;
    @(negedge CLK);
    rst1 = 1'b1;
    @(posedge CLK); #1;
    model_reset();
    access(1'b0, 32'h80, 0);

    access(1'b1, 32'h200, 32'h1111);
    access(1'b0, 32'h280, 0);
    access(1'b1, 32'h300, 32'h3333);
    access(1'b0, 32'h380, 0);
    access(1'b0, 32'h204, 0);
    access(1'b0, 32'h400, 0);
    access(1'b0, 32'h208, 0);
    access(1'b0, 32'h284, 0);
    dw_pct = 30;
    repeat (100) rand_access();
    flush_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
